// File: rtl/acc_pkg.sv
// Shared constants and types for the accumulator read-modify-write engine.
// Lane vectors pack lane i at [i*W +: W]. RD_LAT is the RAM read latency that
// sets the S0->S2 pipeline depth and the two-entry forwarding window.
package acc_pkg;

  localparam int unsigned LANES  = 6;
  localparam int unsigned IN_W   = 16;
  localparam int unsigned ACC_W  = 22;
  localparam int unsigned AW     = 10;
  localparam int unsigned ODEPTH = 4;
  localparam int unsigned RD_LAT = 2;

  typedef logic [AW-1:0]          addr_t;
  typedef logic [LANES*IN_W-1:0]  in_vec_t;
  typedef logic [LANES*ACC_W-1:0] acc_vec_t;

  // One recently written RAM entry, used to bypass the RAM read.
  typedef struct packed {
    logic     valid;
    addr_t    addr;
    acc_vec_t sum;
  } fwd_t;

  typedef struct packed {
    addr_t    addr;
    acc_vec_t sum;
  } out_entry_t;

endpackage

// File: rtl/acc_update_pipe_if.sv
// Bus bundle for acc_update_pipe: input beat stream, accumulator RAM port and
// final-sum output stream.
//   slave  : engine side (drives in_ready, ram_addr/wdata/wvalid, out_*)
//   master : environment side (drives in_*, ram_rdata, out_ready)
interface acc_update_pipe_if
  import acc_pkg::*;
();
  logic     in_valid;
  logic     in_ready;
  addr_t    in_addr;
  in_vec_t  in_data;
  logic     in_first;
  logic     in_last;
  addr_t    ram_addr;
  acc_vec_t ram_wdata;
  logic     ram_wvalid;
  acc_vec_t ram_rdata;
  logic     out_valid;
  logic     out_ready;
  addr_t    out_addr;
  acc_vec_t out_data;

  modport slave (
    input  in_valid, in_addr, in_data, in_first, in_last, ram_rdata, out_ready,
    output in_ready, ram_addr, ram_wdata, ram_wvalid, out_valid, out_addr, out_data
  );

  modport master (
    output in_valid, in_addr, in_data, in_first, in_last, ram_rdata, out_ready,
    input  in_ready, ram_addr, ram_wdata, ram_wvalid, out_valid, out_addr, out_data
  );
endinterface

// File: rtl/acc_lane_add.sv
// Single accumulator lane: sign-extends the partial sum and adds it to base.
// Configuration macro ACC_SAT_EN: when defined the result is clamped to the
// signed ACC_W range, otherwise it wraps modulo 2^ACC_W.
//   base_i : ACC_W-bit signed base value
//   inc_i  : IN_W-bit signed partial sum
//   sum_o  : ACC_W-bit result
module acc_lane_add
  import acc_pkg::*;
(
  input  logic [ACC_W-1:0] base_i,
  input  logic [IN_W-1:0]  inc_i,
  output logic [ACC_W-1:0] sum_o
);

  logic [ACC_W-1:0] inc_ext;
  assign inc_ext = {{(ACC_W-IN_W){inc_i[IN_W-1]}}, inc_i};

`ifdef ACC_SAT_EN
  logic [ACC_W:0] wide;

  always_comb begin
    wide  = {base_i[ACC_W-1], base_i} + {inc_ext[ACC_W-1], inc_ext};
    sum_o = wide[ACC_W-1:0];
    // Top two bits disagree only on overflow; the extra bit holds the true sign.
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      sum_o = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  always_comb begin
    sum_o = base_i + inc_ext;
  end
`endif

endmodule

// File: rtl/acc_update_pipe.sv
// Read-modify-write accumulator engine in front of the LANES-wide accumulator
// RAM. S0 accepts a beat and issues the RAM read, S2 adds the partial sums to
// the read data (or a forwarded recent write) and writes back; beats flagged
// last also push {addr,sum} into a small output FIFO.
// Configuration macro ACC_SAT_EN selects saturating lane adds (see acc_lane_add).
//   clk, rst_n : clock, asynchronous active-low reset
//   acc_bus    : acc_update_pipe_if.slave (input beats, RAM port, output stream)
module acc_update_pipe
  import acc_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  acc_update_pipe_if.slave  acc_bus
);

  localparam int unsigned PtrW = (ODEPTH > 1) ? $clog2(ODEPTH) : 1;
  localparam int unsigned CntW = $clog2(ODEPTH + 1);

  logic       s1_valid_q, s1_first_q, s1_last_q;
  addr_t      s1_addr_q;
  in_vec_t    s1_data_q;
  logic       s2_valid_q, s2_first_q, s2_last_q;
  addr_t      s2_addr_q;
  in_vec_t    s2_data_q;
  fwd_t       fwd0_q, fwd1_q;
  out_entry_t fifo_q [ODEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;

  logic          accept, push, push_ok, pop, nonempty;
  logic [CntW:0] occupancy;
  acc_vec_t      base, sum;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(ODEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reserve FIFO space for last beats still in S1/S2 so the pipe never stalls.
  always_comb begin
    occupancy = {1'b0, cnt_q} + (CntW+1)'(s1_valid_q & s1_last_q)
              + (CntW+1)'(s2_valid_q & s2_last_q);
  end

  assign acc_bus.in_ready = rst_n & (occupancy < (CntW+1)'(ODEPTH));
  assign accept           = acc_bus.in_valid & acc_bus.in_ready;
  assign acc_bus.ram_addr = rst_n ? acc_bus.in_addr : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_addr_q  <= '0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_first_q <= acc_bus.in_first;
        s1_last_q  <= acc_bus.in_last;
        s1_addr_q  <= acc_bus.in_addr;
        s1_data_q  <= acc_bus.in_data;
      end
      s2_valid_q <= s1_valid_q;
      s2_first_q <= s1_first_q;
      s2_last_q  <= s1_last_q;
      s2_addr_q  <= s1_addr_q;
      s2_data_q  <= s1_data_q;
    end
  end

  // RAM reads do not see a write issued in the same cycle, so the last two
  // writes are bypassed; fwd0 is the newer one and takes priority.
  always_comb begin
    if (s2_first_q) begin
      base = '0;
    end else if (fwd0_q.valid && (fwd0_q.addr == s2_addr_q)) begin
      base = fwd0_q.sum;
    end else if (fwd1_q.valid && (fwd1_q.addr == s2_addr_q)) begin
      base = fwd1_q.sum;
    end else begin
      base = acc_bus.ram_rdata;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    acc_lane_add u_lane (
      .base_i (base[i*ACC_W +: ACC_W]),
      .inc_i  (s2_data_q[i*IN_W +: IN_W]),
      .sum_o  (sum[i*ACC_W +: ACC_W])
    );
  end

  assign acc_bus.ram_wvalid = s2_valid_q;
  assign acc_bus.ram_wdata  = s2_valid_q ? sum : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd0_q <= '0;
      fwd1_q <= '0;
    end else begin
      fwd0_q <= '{valid: s2_valid_q, addr: s2_addr_q, sum: sum};
      fwd1_q <= fwd0_q;
    end
  end

  // Output FIFO
  assign nonempty = (cnt_q != '0);
  assign push     = s2_valid_q & s2_last_q;
  assign pop      = nonempty & acc_bus.out_ready;
  assign push_ok  = push & ((cnt_q != CntW'(ODEPTH)) | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= ptr_inc(wptr_q);
      if (pop)     rptr_q <= ptr_inc(rptr_q);
      unique case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wptr_q] <= '{addr: s2_addr_q, sum: sum};
  end

  assign acc_bus.out_valid = nonempty;
  assign acc_bus.out_addr  = nonempty ? fifo_q[rptr_q].addr : '0;
  assign acc_bus.out_data  = nonempty ? fifo_q[rptr_q].sum  : '0;

endmodule
